// File: rtl/logic_gate_pipe_if.sv
// Operand/result handshake bundle for logic_gate_pipe.
// The master side produces operands and consumes results; the slave side is the pipeline.
interface logic_gate_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/logic_gate_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control and a completed-transaction counter.
// Optional y_all/y_any reduction outputs are enabled by defining LOGIC_GATE_PIPE_REDUCE_EN.
module logic_gate_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned XCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    logic_gate_pipe_if.slave  bus,
    output logic [XCNT_W-1:0] xact_count
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    ,
    output logic              y_all,
    output logic              y_any
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("logic_gate_pipe: WIDTH must be in 1..64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("logic_gate_pipe: STAGES must be in 1..4");
    end
    if (XCNT_W < 1) begin : g_bad_xcnt
        $error("logic_gate_pipe: XCNT_W must be at least 1");
    end

    function automatic logic [WIDTH-1:0] gate(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        logic [WIDTH-1:0] r;
        unique case (sel)
            3'b000: r = x & z;
            3'b001: r = x | z;
            3'b010: r = x ^ z;
            3'b011: r = ~(x & z);
            3'b100: r = ~(x | z);
            3'b101: r = ~(x ^ z);
            3'b110: r = x & ~z;
            3'b111: r = x;
        endcase
        return r;
    endfunction

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [STAGES-1:0] ld;
    logic              chain_full;
    logic [WIDTH-1:0]  result;
    logic              accept;
    logic              handshake;
    logic [XCNT_W-1:0] cnt;

    // A stage can load when it, or any stage downstream of it, has a free slot, or the
    // consumer drains the last stage; this is the chain adv[k] = load(k+1) flattened.
    always_comb begin
        chain_full = 1'b1;
        ld         = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            chain_full = chain_full & v[k];
            ld[k]      = !chain_full || bus.out_ready;
        end
    end

    assign result    = gate(bus.op, bus.a, bus.b);
    assign accept    = bus.in_valid && ld[0];
    assign handshake = v[STAGES-1] && bus.out_ready;

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.y         = d[STAGES-1];
    assign xact_count    = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                d[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                v[0] <= bus.in_valid;
                if (accept) begin
                    d[0] <= result;
                end
            end
            // Stages past 0 only delay; data moves only when a valid word arrives.
            for (int k = 1; k < int'(STAGES); k++) begin
                if (ld[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        d[k] <= d[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (handshake) begin
            cnt <= cnt + XCNT_W'(1);
        end
    end

`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    logic [STAGES-1:0] all_r;
    logic [STAGES-1:0] any_r;

    // Reduction flags ride beside d so they stay aligned with y and out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_r <= '0;
            any_r <= '0;
        end else begin
            if (accept) begin
                all_r[0] <= &result;
                any_r[0] <= |result;
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (ld[k] && v[k-1]) begin
                    all_r[k] <= all_r[k-1];
                    any_r[k] <= any_r[k-1];
                end
            end
        end
    end

    assign y_all = all_r[STAGES-1];
    assign y_any = any_r[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized and directed bench for logic_gate_pipe against a transaction-level queue model.
module tb_logic_gate_pipe;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;
    localparam int unsigned XCNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [XCNT_W-1:0] xact_count;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    logic y_all, y_any;
    logic obs_all, obs_any;
`endif

    always #5 clk = ~clk;

    logic_gate_pipe_if #(.WIDTH(WIDTH)) bus ();

    logic_gate_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .XCNT_W (XCNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .xact_count (xact_count)
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
        ,
        .y_all      (y_all),
        .y_any      (y_any)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] val;
        int               rdy;
    } item_t;

    item_t             q[$];
    int                cyc = 0;
    int                cyc_now;
    int                n_checks = 0;
    int                n_pass = 0;
    logic [XCNT_W-1:0] exp_cnt, exp_cnt_now;
    logic              obs_in_ready, obs_out_valid;
    logic [WIDTH-1:0]  obs_y;
    logic [XCNT_W-1:0] obs_cnt;
    logic              exp_in_ready, exp_out_valid;
    logic [WIDTH-1:0]  exp_y;
    logic              acc_now, hs_now;

    function automatic logic [WIDTH-1:0] gate_ref(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return a;
        endcase
    endfunction

    // One clock: drive, sample pre-edge, predict from the model, then advance the model.
    // An accepted item becomes visible STAGES cycles later, or the cycle after its
    // predecessor leaves, whichever is later; the pipe is full when it holds STAGES items.
    task automatic cycle(input logic iv, input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = ordy;
        #1;
        obs_in_ready  = bus.in_ready;
        obs_out_valid = bus.out_valid;
        obs_y         = bus.y;
        obs_cnt       = xact_count;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
        obs_all = y_all;
        obs_any = y_any;
`endif
        cyc_now       = cyc;
        exp_cnt_now   = exp_cnt;
        exp_in_ready  = (q.size() < int'(STAGES)) || ordy;
        exp_out_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_y         = exp_out_valid ? q[0].val : '0;
        acc_now       = iv && exp_in_ready;
        hs_now        = exp_out_valid && ordy;
        @(posedge clk);
        if (hs_now) begin
            void'(q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
            if (q.size() > 0 && q[0].rdy < cyc + 1) q[0].rdy = cyc + 1;
        end
        if (acc_now) q.push_back('{gate_ref(op, a, b), cyc + int'(STAGES)});
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.y !== 8'h00) $display("FAIL rst_y got=%h exp=00", bus.y); else n_pass++;
        n_checks++; if (xact_count !== 4'd0) $display("FAIL rst_cnt got=%0d exp=0", xact_count); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'd0, '0, '0, 1'b1);
            n_checks++; if (obs_out_valid !== 1'b0 || obs_y !== 8'h00) $display("FAIL idle_out got_v=%b got_y=%h exp_v=0 exp_y=00", obs_out_valid, obs_y); else n_pass++;
            n_checks++; if (obs_in_ready !== 1'b1 || obs_cnt !== 4'd0) $display("FAIL idle_ready_cnt got_r=%b got_c=%0d exp_r=1 exp_c=0", obs_in_ready, obs_cnt); else n_pass++;
        end
    endtask

    task automatic test_all_ops();
        logic [WIDTH-1:0] expv [8];
        int nout, start;
        expv  = '{8'h48, 8'hDE, 8'h96, 8'hB7, 8'h21, 8'h69, 8'h82, 8'hCA};
        nout  = 0;
        do_reset();
        start = cyc;
        for (int i = 0; i < 10; i++) begin
            cycle(i < 8, 3'(i), 8'hCA, 8'h5C, 1'b1);
            n_checks++; if (obs_in_ready !== 1'b1) $display("FAIL ops_in_ready i=%0d got=%b exp=1", i, obs_in_ready); else n_pass++;
            if (obs_out_valid === 1'b1 && nout < 8) begin
                n_checks++; if (obs_y !== expv[nout]) $display("FAIL ops_y n=%0d got=%h exp=%h", nout, obs_y, expv[nout]); else n_pass++;
                n_checks++; if (cyc_now - (start + nout) != 2) $display("FAIL ops_latency n=%0d got=%0d exp=2", nout, cyc_now - (start + nout)); else n_pass++;
                nout++;
            end
        end
        cycle(1'b0, 3'd0, '0, '0, 1'b1);
        n_checks++; if (nout != 8) $display("FAIL ops_count got=%0d exp=8", nout); else n_pass++;
        n_checks++; if (obs_cnt !== 4'd8) $display("FAIL ops_xact got=%0d exp=8", obs_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [2:0]       ops [3];
        logic [WIDTH-1:0] as [3], bs [3], hold;
        logic [WIDTH-1:0] outs [$];
        for (int i = 0; i < 3; i++) begin
            ops[i] = 3'($urandom_range(0, 7));
            as[i]  = 8'($urandom);
            bs[i]  = 8'($urandom);
        end
        do_reset();
        cycle(1'b1, ops[0], as[0], bs[0], 1'b0);
        n_checks++; if (obs_in_ready !== 1'b1) $display("FAIL bp_ready0 got=%b exp=1", obs_in_ready); else n_pass++;
        cycle(1'b1, ops[1], as[1], bs[1], 1'b0);
        n_checks++; if (obs_in_ready !== 1'b1) $display("FAIL bp_ready1 got=%b exp=1", obs_in_ready); else n_pass++;
        cycle(1'b1, ops[2], as[2], bs[2], 1'b0);
        n_checks++; if (obs_in_ready !== 1'b0) $display("FAIL bp_full got=%b exp=0", obs_in_ready); else n_pass++;
        n_checks++; if (obs_out_valid !== 1'b1 || obs_y !== gate_ref(ops[0], as[0], bs[0])) $display("FAIL bp_head got_v=%b got_y=%h exp_y=%h", obs_out_valid, obs_y, gate_ref(ops[0], as[0], bs[0])); else n_pass++;
        hold = obs_y;
        cycle(1'b1, ops[2], as[2], bs[2], 1'b0);
        n_checks++; if (obs_y !== hold || obs_in_ready !== 1'b0) $display("FAIL bp_stable got_y=%h exp_y=%h got_r=%b", obs_y, hold, obs_in_ready); else n_pass++;
        cycle(1'b1, ops[2], as[2], bs[2], 1'b1);
        n_checks++; if (obs_in_ready !== 1'b1) $display("FAIL bp_drain_ready got=%b exp=1", obs_in_ready); else n_pass++;
        if (obs_out_valid === 1'b1) outs.push_back(obs_y);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'd0, '0, '0, 1'b1);
            if (obs_out_valid === 1'b1) outs.push_back(obs_y);
        end
        n_checks++; if (outs.size() != 3) $display("FAIL bp_outs got=%0d exp=3", outs.size()); else n_pass++;
        for (int i = 0; i < 3 && i < outs.size(); i++) begin
            n_checks++; if (outs[i] !== gate_ref(ops[i], as[i], bs[i])) $display("FAIL bp_order i=%0d got=%h exp=%h", i, outs[i], gate_ref(ops[i], as[i], bs[i])); else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i < 380)
                cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                      8'($urandom), $urandom_range(0, 9) < 6);
            else
                cycle(1'b0, 3'd0, '0, '0, 1'b1);
            n_checks++; if (obs_in_ready !== exp_in_ready) $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc_now, obs_in_ready, exp_in_ready); else n_pass++;
            n_checks++; if (obs_out_valid !== exp_out_valid) $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc_now, obs_out_valid, exp_out_valid); else n_pass++;
            n_checks++; if (obs_cnt !== exp_cnt_now) $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc_now, obs_cnt, exp_cnt_now); else n_pass++;
            if (exp_out_valid) begin
                n_checks++; if (obs_y !== exp_y) $display("FAIL rnd_y cyc=%0d got=%h exp=%h", cyc_now, obs_y, exp_y); else n_pass++;
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
                n_checks++; if (obs_all !== (&exp_y) || obs_any !== (|exp_y)) $display("FAIL rnd_reduce cyc=%0d got=%b%b exp=%b%b", cyc_now, obs_all, obs_any, &exp_y, |exp_y); else n_pass++;
`endif
            end
        end
        n_checks++; if (obs_out_valid !== 1'b0) $display("FAIL rnd_drained got=%b exp=0", obs_out_valid); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, '0, '0, 1'b1);
        n_checks++; if (obs_cnt !== 4'd1) $display("FAIL wrap_cnt got=%0d exp=1", obs_cnt); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 3'd7, 8'hA5, 8'h00, 1'b0);
        cycle(1'b1, 3'd1, 8'h3C, 8'h81, 1'b0);
        cycle(1'b0, 3'd0, '0, '0, 1'b0);
        n_checks++; if (obs_out_valid !== 1'b1 || obs_y !== 8'hA5) $display("FAIL arst_pre got_v=%b got_y=%h exp_v=1 exp_y=a5", obs_out_valid, obs_y); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.y !== 8'h00) $display("FAIL arst_now got_v=%b got_y=%h exp_v=0 exp_y=00", bus.out_valid, bus.y); else n_pass++;
        n_checks++; if (xact_count !== 4'd0 || bus.in_ready !== 1'b1) $display("FAIL arst_state got_c=%0d got_r=%b exp_c=0 exp_r=1", xact_count, bus.in_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 3'd0, '0, '0, 1'b1);
            n_checks++; if (obs_out_valid !== 1'b0 || obs_cnt !== 4'd0) $display("FAIL arst_stale i=%0d got_v=%b got_c=%0d exp_v=0 exp_c=0", i, obs_out_valid, obs_cnt); else n_pass++;
        end
    endtask

`ifdef LOGIC_GATE_PIPE_REDUCE_EN
    task automatic test_reduce();
        do_reset();
        cycle(1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1);
        cycle(1'b1, 3'd0, 8'h0F, 8'hF0, 1'b1);
        cycle(1'b0, 3'd0, '0, '0, 1'b1);
        n_checks++; if (obs_out_valid !== 1'b1 || obs_all !== 1'b1 || obs_any !== 1'b1) $display("FAIL reduce_ff got_v=%b got=%b%b exp=11", obs_out_valid, obs_all, obs_any); else n_pass++;
        cycle(1'b0, 3'd0, '0, '0, 1'b1);
        n_checks++; if (obs_out_valid !== 1'b1 || obs_all !== 1'b0 || obs_any !== 1'b0) $display("FAIL reduce_00 got_v=%b got=%b%b exp=00", obs_out_valid, obs_all, obs_any); else n_pass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_cnt = '0;
        test_reset();
        test_all_ops();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
`ifdef LOGIC_GATE_PIPE_REDUCE_EN
        test_reduce();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, pipelined bitwise logic unit. Each accepted transaction applies one of eight two-operand bitwise operations, selected per transaction, to a pair of WIDTH-bit operands. The result passes through a STAGES-deep register pipeline with valid/ready flow control on both sides. The block is the general-purpose successor to the single-bit registered gate cells and sits between operand producers and any result consumer that can apply backpressure.

## Interface
- WIDTH, 8: operand and result width in bits, 1..64.
- STAGES, 2: pipeline depth in register stages, 1..4.
- XCNT_W, 16: width of the completed-transaction counter.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block accepts a transaction this cycle.
- op  input  3  operation select, sampled on accept.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  y holds a valid result.
- out_ready  input  1  consumer accepts y this cycle.
- y  output  WIDTH  result.
- xact_count  output  XCNT_W  number of completed output handshakes, modulo 2^XCNT_W.

## Operation
- Accept occurs when in_valid && in_ready. Output handshake occurs when out_valid && out_ready.
- op encoding:
  - 000: a&b
  - 001: a|b
  - 010: a^b
  - 011: ~(a&b)
  - 100: ~(a|b)
  - 101: ~(a^b)
  - 110: a&~b
  - 111: a (pass)
  - All codes are legal.
- The result is computed combinationally from a, b and op at accept and captured into stage 0. Stages 1..STAGES-1 only delay the result and its valid bit.
- Each stage k holds one valid bit v[k] and one data register d[k].
- Stage k loads when !v[k] || adv[k]. adv[last] = out_ready; adv[k] = the load condition of stage k+1.
- When a stage advances without loading, its v[k] clears.
- in_ready = !v[0] || adv[0]. This is a combinational path from out_ready; the block has no skid buffer.
- out_valid = v[STAGES-1]; y = d[STAGES-1].
- y holds its value while out_valid && !out_ready. Data registers of invalid stages need not change.
- xact_count increments by 1 on each output handshake and wraps from all-ones to 0.
- Reset: v[] = 0, d[] = 0, y = 0, out_valid = 0, xact_count = 0. in_ready = 1 immediately after reset deasserts.
- Reset asserted mid-operation discards all in-flight transactions; no partial output appears.

## Timing
- Latency: a transaction accepted at edge N presents out_valid at edge N+STAGES, provided the pipeline is not stalled.
- Throughput: one transaction per cycle while out_ready stays high.
- Full pipeline: all v = 1 with out_ready = 0 gives in_ready = 0. Raising out_ready gives in_ready = 1 in the same cycle (accept and drain together).
- Empty pipeline: out_valid = 0; out_ready is ignored.
- Bubbles collapse: an invalid stage accepts from its predecessor even while downstream is stalled.
- Order is preserved; transactions are never dropped or duplicated.

## Configuration
- LOGIC_GATE_PIPE_REDUCE_EN defined: adds two outputs, each 1 bit wide.
  - y_all = &result
  - y_any = |result
  - Both are computed at stage 0 and carried through the pipeline beside d, so they align with y and out_valid.
  - Both reset to 0.
- LOGIC_GATE_PIPE_REDUCE_EN undefined: y_all and y_any ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Reset then idle, WIDTH = 8, STAGES = 2: out_valid = 0, y = 0x00, xact_count = 0, in_ready = 1.
- All eight ops with a = 0xCA, b = 0x5C and out_ready = 1 held, one accept per cycle: outputs arrive in order, 2 cycles after each accept, as 0x48, 0xDE, 0x96, 0xB7, 0x21, 0x69, 0x82, 0xCA. xact_count ends at 8.
- Backpressure: fill with 3 transactions while out_ready = 0. in_ready drops once the 2 stages are full and y stays stable. Then raise out_ready for 3 cycles: all 3 results emerge in order with no loss.
- Wrap: XCNT_W = 4, 17 handshakes: xact_count reads 1.
- Reset asserted asynchronously with 2 transactions in flight: out_valid and y go to 0 before the next clock edge, and no stale result appears after release.
- With LOGIC_GATE_PIPE_REDUCE_EN defined, op = 000, a = 0xFF, b = 0xFF: y_all = 1, y_any = 1. Then a = 0x0F, b = 0xF0: y_all = 0, y_any = 0.
